// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing generator.
//   - default 640x480@60 timing values (pixel units / line units)
//   - helpers computing the total line / frame length from the four segments
//   - the eight-entry colour-bar table used by the optional test pattern
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // One bit per channel; the output stage replicates it across CW bits.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } bar_rgb_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic bar_rgb_t bar_rgb(input logic [2:0] idx);
        bar_rgb_t c;
        case (idx)
            3'd0:    c = '{r: 1'b1, g: 1'b1, b: 1'b1};
            3'd1:    c = '{r: 1'b1, g: 1'b1, b: 1'b0};
            3'd2:    c = '{r: 1'b0, g: 1'b1, b: 1'b1};
            3'd3:    c = '{r: 1'b0, g: 1'b1, b: 1'b0};
            3'd4:    c = '{r: 1'b1, g: 1'b0, b: 1'b1};
            3'd5:    c = '{r: 1'b1, g: 1'b0, b: 1'b0};
            3'd6:    c = '{r: 1'b0, g: 1'b0, b: 1'b1};
            default: c = '{r: 1'b0, g: 1'b0, b: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: link between the timing generator and the upstream
// pixel source.
//   pos_x  [10:0]  current horizontal count (timing gen -> source)
//   pos_y  [9:0]   current vertical count   (timing gen -> source)
//   pix_ce         one-clk pixel-tick strobe (timing gen -> source)
//   pix_r/g/b [CW] colour for pos_x/pos_y     (source -> timing gen)
//
// Handshake: there is no ready/back-pressure. pos_x/pos_y are stable from one
// pix_ce to the next; the source must present the colour of that coordinate
// before the clk edge on which pix_ce is high, where it is captured. Colour
// is ignored (and may be X) whenever the coordinate is outside the active area.
interface vga_timing_gen_if #(parameter int CW = 4) ();
    logic [10:0]   pos_x;
    logic [9:0]    pos_y;
    logic          pix_ce;
    logic [CW-1:0] pix_r;
    logic [CW-1:0] pix_g;
    logic [CW-1:0] pix_b;

    modport master (output pos_x, pos_y, pix_ce, input pix_r, pix_g, pix_b);
    modport slave  (input pos_x, pos_y, pix_ce, output pix_r, pix_g, pix_b);
endinterface

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one raster axis (horizontal or vertical) counter.
//   clk, rst     clock, synchronous active-high reset
//   ce           advance strobe (pixel tick for H, H wrap for V)
//   wrap_in      step qualifier; the counter moves only when ce && wrap_in
//   cnt [W]      current position, 0..ACTIVE+FP+SYNC+BP-1
//   active       cnt inside the visible segment
//   sync_region  cnt inside the sync segment (after the front porch)
//   wrap_out     high on the step that returns cnt to 0
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         wrap_in,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync_region,
    output logic         wrap_out
);
    localparam int           TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic step;

    assign step     = ce & wrap_in;
    assign wrap_out = step && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign active      = (cnt < ACT_END);
    assign sync_region = (cnt >= SYNC_START) && (cnt < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with blanked RGB output stage.
//   clk, rst        system clock, synchronous active-high reset
//   pat_sel         (only with VGA_PATTERN_EN) 1 = colour bars replace pix_*
//   pix             pixel-source link (pos_x/pos_y/pix_ce out, pix_r/g/b in)
//   out_R/G/B [CW]  registered colour, 0 while blanked
//   Hsync, Vsync    registered syncs, polarity set by SYNC_POL
//   de              registered display enable
//   frame_start     one-clk pulse alongside the first de of each frame
// Optional build macro: VGA_PATTERN_EN adds the pat_sel colour-bar generator.
// All registered outputs describe the coordinate that pos_x/pos_y held one
// pixel tick earlier.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SYNC_POL = 0,
    parameter int CW       = 4,
    parameter int PIX_DIV  = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VGA_PATTERN_EN
    input  logic             pat_sel,
`endif
    vga_timing_gen_if.master pix,
    output logic [CW-1:0]    out_R,
    output logic [CW-1:0]    out_G,
    output logic [CW-1:0]    out_B,
    output logic             Hsync,
    output logic             Vsync,
    output logic             de,
    output logic             frame_start
);
    localparam int            DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic          POL      = (SYNC_POL != 0);

    logic [DW-1:0] div_cnt;
    logic          pix_ce;
    logic [10:0]   h_cnt;
    logic [9:0]    v_cnt;
    logic          h_act, h_sync, h_wrap;
    logic          v_act, v_sync, v_wrap;
    logic          de_next;
    logic          frame_top;
    logic [CW-1:0] src_r, src_g, src_b;

    // Pixel-rate divider; with PIX_DIV=1 div_cnt stays 0 and pix_ce is constant.
    assign pix_ce = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(11)
    ) u_h_cnt (
        .clk(clk), .rst(rst), .ce(pix_ce), .wrap_in(1'b1),
        .cnt(h_cnt), .active(h_act), .sync_region(h_sync), .wrap_out(h_wrap)
    );

    vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(10)
    ) u_v_cnt (
        .clk(clk), .rst(rst), .ce(h_wrap), .wrap_in(1'b1),
        .cnt(v_cnt), .active(v_act), .sync_region(v_sync), .wrap_out(v_wrap)
    );

    assign pix.pos_x  = h_cnt;
    assign pix.pos_y  = v_cnt;
    assign pix.pix_ce = pix_ce;
    assign de_next    = h_act & v_act;

`ifdef VGA_PATTERN_EN
    logic [2:0] bar_idx;
    bar_rgb_t   bar;

    // Index is only meaningful inside the active area; blanking masks the rest.
    assign bar_idx = 3'(int'(h_cnt) / (H_ACTIVE / 8));
    assign bar     = bar_rgb(bar_idx);

    always_comb begin
        src_r = pix.pix_r;
        src_g = pix.pix_g;
        src_b = pix.pix_b;
        if (pat_sel) begin
            src_r = {CW{bar.r}};
            src_g = {CW{bar.g}};
            src_b = {CW{bar.b}};
        end
    end
`else
    assign src_r = pix.pix_r;
    assign src_g = pix.pix_g;
    assign src_b = pix.pix_b;
`endif

    // frame_top marks that the counters sit at (0,0): set by reset or by the
    // vertical wrap, consumed by the next pixel tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_top <= 1'b1;
        end else if (pix_ce) begin
            frame_top <= v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce & frame_top;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de    <= 1'b0;
            Hsync <= ~POL;
            Vsync <= ~POL;
            out_R <= '0;
            out_G <= '0;
            out_B <= '0;
        end else if (pix_ce) begin
            de    <= de_next;
            Hsync <= POL ^ ~h_sync;
            Vsync <= POL ^ ~v_sync;
            // Muxing to 0 keeps an undriven source from leaking X while blanked.
            out_R <= de_next ? src_r : '0;
            out_G <= de_next ? src_g : '0;
            out_B <= de_next ? src_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // dut0: default 640x480 timing, PIX_DIV=2, active-low syncs
  vga_timing_gen_if #(.CW(4)) bus0 ();
  logic [3:0] r0, g0, b0;
  logic       hs0, vs0, de0, fs0;
`ifdef VGA_PATTERN_EN
  logic       pat_sel0 = 1'b0;
  logic       pat_sel1 = 1'b0;
`endif

  assign bus0.pix_r = 4'hF;
  assign bus0.pix_g = 4'hF;
  assign bus0.pix_b = 4'hF;

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst0),
`ifdef VGA_PATTERN_EN
    .pat_sel(pat_sel0),
`endif
    .pix(bus0),
    .out_R(r0), .out_G(g0), .out_B(b0),
    .Hsync(hs0), .Vsync(vs0), .de(de0), .frame_start(fs0)
  );

  // dut1: tiny 12x7 raster, PIX_DIV=1, active-high syncs
  vga_timing_gen_if #(.CW(4)) bus1 ();
  logic [3:0] r1, g1, b1;
  logic       hs1, vs1, de1, fs1;

  assign bus1.pix_r = bus1.pos_x[3:0] + 4'd1;
  assign bus1.pix_g = bus1.pos_y[3:0] + 4'd5;
  assign bus1.pix_b = 4'hA;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .CW(4), .PIX_DIV(1)
  ) dut1 (
    .clk(clk), .rst(rst1),
`ifdef VGA_PATTERN_EN
    .pat_sel(pat_sel1),
`endif
    .pix(bus1),
    .out_R(r1), .out_G(g1), .out_B(b1),
    .Hsync(hs1), .Vsync(vs1), .de(de1), .frame_start(fs1)
  );

  typedef struct {
    int          k;
    logic [10:0] x;
    logic [9:0]  y;
    logic        de, hs, vs, fs;
    logic [3:0]  r, g, b;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];
  int   nv = 0;

  task automatic add_vec(input int k, input int x, input int y, input bit de, input bit hs,
                         input bit vs, input bit fs, input int r, input int g, input int b);
    vt[nv].k  = k;
    vt[nv].x  = 11'(x);
    vt[nv].y  = 10'(y);
    vt[nv].de = de;
    vt[nv].hs = hs;
    vt[nv].vs = vs;
    vt[nv].fs = fs;
    vt[nv].r  = 4'(r);
    vt[nv].g  = 4'(g);
    vt[nv].b  = 4'(b);
    nv++;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_x0(input logic [10:0] x, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus0.pos_x == x) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [63:0] pack1();
    return 64'({bus1.pos_x, bus1.pos_y, de1, hs1, vs1, fs1, r1, g1, b1});
  endfunction

  initial begin
    int vi;
    int hs_hi, vs_hi, fs_n, de_n, hs_rise, hs_bad_int, last_rise, fs_bad;
    int pce_n, hs_lo, vs_lo, viol, fall1, fall2;
    bit prev_hs, prev_de, ok;

    // k = clk edges after reset release; registered fields describe tick k-1.
    //      k   x  y de hs vs fs  r  g  b
    add_vec(0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1,  1, 0, 1, 0, 0, 1, 1, 5, 10);
    add_vec(2,  2, 0, 1, 0, 0, 0, 2, 5, 10);
    add_vec(8,  8, 0, 1, 0, 0, 0, 8, 5, 10);
    add_vec(9,  9, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(10, 10, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(11, 11, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(12, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(13, 1, 1, 1, 0, 0, 0, 1, 6, 10);
    add_vec(37, 1, 3, 1, 0, 0, 0, 1, 8, 10);
    add_vec(48, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    add_vec(49, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    add_vec(61, 1, 5, 0, 0, 1, 0, 0, 0, 0);
    add_vec(72, 0, 6, 0, 0, 1, 0, 0, 0, 0);
    add_vec(73, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    add_vec(84, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(85, 1, 0, 1, 0, 0, 1, 1, 5, 10);
    add_vec(86, 2, 0, 1, 0, 0, 0, 2, 5, 10);

    // ---------------- clock/reset ----------------
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // ---------------- dut1 vector table ----------------
    vi = 0;
    if (vt[0].k == 0) begin
      check("vec_k0", pack1(), 64'({vt[0].x, vt[0].y, vt[0].de, vt[0].hs, vt[0].vs, vt[0].fs,
                                   vt[0].r, vt[0].g, vt[0].b}));
      vi = 1;
    end
    rst1 = 1'b0;
    for (int k = 1; k <= 86; k++) begin
      tick();
      if (vi < nv && vt[vi].k == k) begin
        check($sformatf("vec_k%0d", k), pack1(),
              64'({vt[vi].x, vt[vi].y, vt[vi].de, vt[vi].hs, vt[vi].vs, vt[vi].fs,
                   vt[vi].r, vt[vi].g, vt[vi].b}));
        vi++;
      end
    end
    check("vec_count", 64'(vi), 64'(NV));

    // ---------------- dut1 two-frame window (168 clk) ----------------
    hs_hi = 0; vs_hi = 0; fs_n = 0; de_n = 0; hs_rise = 0; hs_bad_int = 0;
    last_rise = -1; fs_bad = 0;
    prev_hs = hs1; prev_de = de1;
    for (int c = 0; c < 168; c++) begin
      tick();
      if (hs1) hs_hi++;
      if (vs1) vs_hi++;
      if (de1) de_n++;
      if (fs1) begin
        fs_n++;
        if (!de1 || prev_de) fs_bad++;
      end
      if (hs1 && !prev_hs) begin
        hs_rise++;
        if (last_rise >= 0 && (c - last_rise) != 12) hs_bad_int++;
        last_rise = c;
      end
      prev_hs = hs1;
      prev_de = de1;
    end
    check("small_hsync_high_clk", 64'(hs_hi), 64'd28);
    check("small_hsync_rises", 64'(hs_rise), 64'd14);
    check("small_hsync_period", 64'(hs_bad_int), 64'd0);
    check("small_vsync_high_clk", 64'(vs_hi), 64'd24);
    check("small_de_clk", 64'(de_n), 64'd64);
    check("small_frame_start_n", 64'(fs_n), 64'd2);
    check("small_fs_at_first_de", 64'(fs_bad), 64'd0);

    // ---------------- dut0 default timing ----------------
    rst0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("def_reset_state", 64'({bus0.pos_x, bus0.pos_y, bus0.pix_ce, de0, hs0, vs0, fs0, r0, g0, b0}),
          64'({11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000}));
    rst0 = 1'b0;

    pce_n = 0; hs_lo = 0; vs_lo = 0; de_n = 0; fs_n = 0; viol = 0; fall1 = -1; fall2 = -1;
    prev_hs = hs0;
    for (int c = 1; c <= 3200; c++) begin
      tick();
      if (bus0.pix_ce) pce_n++;
      if (!hs0) hs_lo++;
      if (!vs0) vs_lo++;
      if (de0) de_n++;
      if (fs0) fs_n++;
      if ((de0 && {r0, g0, b0} != 12'hFFF) || (!de0 && {r0, g0, b0} != 12'h000)) viol++;
      if (!hs0 && prev_hs) begin
        if (fall1 < 0) fall1 = c;
        else if (fall2 < 0) fall2 = c;
      end
      prev_hs = hs0;
    end
    check("def_pix_ce_n", 64'(pce_n), 64'd1600);
    check("def_hsync_low_clk", 64'(hs_lo), 64'd384);
    check("def_hsync_first_fall", 64'(fall1), 64'd1314);
    check("def_hsync_period", 64'(fall2 - fall1), 64'd1600);
    check("def_vsync_low_clk", 64'(vs_lo), 64'd0);
    check("def_de_clk", 64'(de_n), 64'd2560);
    check("def_frame_start_n", 64'(fs_n), 64'd1);
    check("def_rgb_vs_de", 64'(viol), 64'd0);

    // ---------------- mid-line reset ----------------
    wait_x0(11'd300, 2000, ok);
    check("wait_pos_x300", 64'(ok), 64'd1);
    check("pre_reset_de", 64'({de0, r0}), 64'({1'b1, 4'hF}));
    rst0 = 1'b1;
    tick();
    check("midline_reset_state",
          64'({bus0.pos_x, bus0.pos_y, bus0.pix_ce, de0, hs0, vs0, fs0, r0, g0, b0}),
          64'({11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000}));
    rst0 = 1'b0;
    tick();
    check("release_clk1", 64'({bus0.pos_x, bus0.pix_ce, de0, fs0}), 64'({11'd0, 1'b1, 1'b0, 1'b0}));
    tick();
    check("release_clk2", 64'({bus0.pos_x, bus0.pix_ce, de0, fs0, r0}),
          64'({11'd1, 1'b0, 1'b1, 1'b1, 4'hF}));
    tick();
    check("release_clk3", 64'({bus0.pos_x, bus0.pix_ce, de0, fs0}), 64'({11'd1, 1'b1, 1'b1, 1'b0}));

`ifdef VGA_PATTERN_EN
    // ---------------- colour bars ----------------
    pat_sel0 = 1'b1;
    wait_x0(11'd81, 400, ok);
    check("bar_px80_yellow", 64'({ok, r0, g0, b0}), 64'({1'b1, 12'hFF0}));
    wait_x0(11'd640, 1400, ok);
    check("bar_px639_black", 64'({ok, de0, r0, g0, b0}), 64'({1'b1, 1'b1, 12'h000}));
    pat_sel0 = 1'b0;
    wait_x0(11'd101, 3400, ok);
    check("bar_off_passthru", 64'({ok, bus0.pos_y, r0, g0, b0}), 64'({1'b1, 10'd1, 12'hFFF}));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
